// File: rtl/vgpr_wfid_done_queue_if.sv
// Completion capture / done-stream interface between the write-port selector,
// the done queue and the issue/scoreboard consumer.
interface vgpr_wfid_done_queue_if;
    logic [15:0] wr_port_select;
    logic [5:0]  muxed_wfid;
    logic        muxed_wfid_done;
    logic        done_ready;
    logic        done_valid;
    logic [5:0]  done_wfid;
    logic [2:0]  done_port;

    modport master (
        output wr_port_select, muxed_wfid, muxed_wfid_done, done_ready,
        input  done_valid, done_wfid, done_port
    );

    modport slave (
        input  wr_port_select, muxed_wfid, muxed_wfid_done, done_ready,
        output done_valid, done_wfid, done_port
    );
endinterface

// File: rtl/vgpr_wfid_done_queue.sv
// Buffers VGPR write-port completions (wfid + port index) for the scoreboard.
// Optional retire/drop counters are enabled by defining VGPR_DONE_PERF_CNT_EN.
module vgpr_wfid_done_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    vgpr_wfid_done_queue_if.slave    bus,
    input  logic                     err_clear,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     fifo_full,
    output logic                     overflow_err,
    output logic                     sel_error
`ifdef VGPR_DONE_PERF_CNT_EN
    ,
    output logic [31:0]              retire_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [8:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow_err;
    logic             r_sel_error;

    logic [7:0]       w_low;
    logic             w_hi_zero;
    logic             w_onehot;
    logic             w_push_req;
    logic             w_sel_bad;
    logic [2:0]       w_port_idx;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [8:0]       w_head;

    assign w_low      = bus.wr_port_select[7:0];
    assign w_hi_zero  = (bus.wr_port_select[15:8] == 8'h00);
    assign w_onehot   = (w_low != 8'h00) && ((w_low & (w_low - 8'd1)) == 8'h00);
    assign w_push_req = bus.muxed_wfid_done && w_hi_zero && w_onehot;
    // An all-zero select with done is treated as "no port", not an error.
    assign w_sel_bad  = bus.muxed_wfid_done && (bus.wr_port_select != 16'h0000)
                        && !(w_hi_zero && w_onehot);

    always_comb begin
        w_port_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_low[i]) w_port_idx = 3'(i);
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = w_valid && bus.done_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    assign bus.done_valid = w_valid;
    assign bus.done_wfid  = w_valid ? w_head[8:3] : 6'd0;
    assign bus.done_port  = w_valid ? w_head[2:0] : 3'd0;
    assign fifo_count     = r_count;
    assign fifo_full      = w_full;
    assign overflow_err   = r_overflow_err;
    assign sel_error      = r_sel_error;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.muxed_wfid, w_port_idx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow_err <= 1'b0;
            r_sel_error    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow_err <= (r_overflow_err && !err_clear) || w_drop;
            r_sel_error    <= (r_sel_error && !err_clear) || w_sel_bad;
        end
    end

`ifdef VGPR_DONE_PERF_CNT_EN
    logic [31:0] r_retire_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= 32'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            if (w_pop) r_retire_cnt <= r_retire_cnt + 32'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign drop_cnt   = r_drop_cnt;
`endif

endmodule

// File: doc/vgpr_wfid_done_queue.md
Name: vgpr_wfid_done_queue

Overview:
- Sits directly downstream of the 8-way write-port wfid selector in the VGPR.
- Captures each selected write-port completion (muxed_wfid, muxed_wfid_done) together with the index of the write port that produced it.
- Buffers completions in a small FIFO and hands them one per cycle, with a valid/ready handshake, to the issue/scoreboard logic that releases wavefront dependencies.
- Also reports illegal port-select encodings and queue overflow.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- wr_port_select  input  16  write-port select, same encoding the selector consumes.
- muxed_wfid  input  6  selected wavefront id.
- muxed_wfid_done  input  1  selected port signals instruction completion.
- done_ready  input  1  consumer accepts the head entry this cycle.
- err_clear  input  1  clears the sticky error flags.
- done_valid  output  1  head entry is available.
- done_wfid  output  6  wfid of the head entry.
- done_port  output  3  write-port index (0-7) of the head entry.
- fifo_count  output  CNT_W  current occupancy.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow_err  output  1  sticky: a completion was dropped.
- sel_error  output  1  sticky: illegal select encoding seen together with a done.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rd_ptr, wr_ptr and fifo_count go to 0.
  - overflow_err and sel_error go to 0.
  - done_valid=0, done_wfid=0, done_port=0.
  - Reset mid-operation discards all queued entries. Storage contents need not be cleared.
- Capture qualification, evaluated each cycle:
  - push_req = muxed_wfid_done && wr_port_select[15:8]==0 && wr_port_select[7:0] is one-hot.
  - done_port for the pushed entry = bit index of the set bit.
- Select encodings when muxed_wfid_done=1:
  - wr_port_select==0: no push, no error.
  - Zero-hot low byte with upper bits set, multi-hot, or any bit in [15:8] set: no push; sel_error set the next cycle.
- When muxed_wfid_done=0: the select value is ignored entirely.
- Pop:
  - pop = done_valid && done_ready.
  - done_ready while empty has no effect.
- Push:
  - Writes {muxed_wfid, port_idx} at wr_ptr on the clk edge.
  - Latency: an entry pushed at edge N is visible on done_valid/done_wfid/done_port after edge N. There is no same-cycle bypass, including when the FIFO is empty.
- Outputs:
  - done_valid = (fifo_count != 0).
  - done_wfid/done_port read combinationally from the entry at rd_ptr.
  - done_wfid/done_port are forced to 0 while empty.
- Pointers: wrap modulo DEPTH; fifo_count is incremented/decremented as below.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance. This holds when full (push accepted) and when count==1.
  - Push while full without pop: entry dropped, count unchanged, overflow_err set.
  - Pop while empty: not possible, since done_valid=0.
- Sticky errors:
  - Stay set until err_clear=1.
  - If a new error event occurs in the same cycle as err_clear, the flag remains 1 (set wins).
- fifo_full is combinational from fifo_count. Upstream may use it as backpressure, but this block never stalls the write ports.

Optional Feature:
- Macro: VGPR_DONE_PERF_CNT_EN.
- When defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments by 1 on every pop; wraps 0xFFFFFFFF -> 0.
  - Also adds output drop_cnt [15:0], reset to 0, incremented on every dropped push and saturating at 0xFFFF.
  - Neither counter is affected by err_clear.
- When undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a single push (select=16'h0004, wfid=6'd17, done=1) with done_ready=0 -> next cycle done_valid=1, done_wfid=17, done_port=2, fifo_count=1. Raise done_ready for one cycle -> done_valid=0, count=0.
- 8 pushes on back-to-back cycles (select 16'h0001..16'h0080, wfid 0..7) with done_ready=0 -> fifo_full=1. A 9th push -> overflow_err=1, count stays 8. Drain -> wfids 0..7 in order with ports 0..7; pointers wrap correctly on a second fill of 8.
- Full FIFO, push and pop in the same cycle -> count stays 8, overflow_err stays 0, and the new entry emerges last.
- done=1 with select=16'h0003, then 16'h0100 -> no push, sel_error=1. Assert err_clear together with another bad select -> sel_error stays 1. Clean err_clear -> 0. done=1 with select=0 -> no push, no error.
- Assert rst with 5 entries queued and done_ready=1 -> next cycle done_valid=0, count=0, errors 0, done_wfid=0.
- With VGPR_DONE_PERF_CNT_EN defined: 10 pushes with 2 drops and 8 pops -> retire_cnt=8, drop_cnt=2. Preload retire_cnt at 0xFFFFFFFF, then one pop -> retire_cnt=0.
